// File: rtl/hazard_pkg.sv
// Shared constants for the RV32I hazard controller:
// FSM encoding, forwarding-select bit positions and the x0 register index.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_e;

   localparam int RS1_BIT = 1;
   localparam int RS2_BIT = 0;

   localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Source-vs-destination comparator for one ID source register.
// Emits at most one of ex/mem/wb forward or load-use, EX > MEM > WB.
module fwd_match
   import hazard_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic       use_i,
   input  logic [4:0] ex_wreg_i,
   input  logic       ex_we_i,
   input  logic       ex_load_i,
   input  logic [4:0] mem_wreg_i,
   input  logic       mem_we_i,
   input  logic [4:0] wb_wreg_i,
   input  logic       wb_we_i,
   output logic       ex_fwd_o,
   output logic       mem_fwd_o,
   output logic       wb_fwd_o,
   output logic       load_use_o
);

   logic live;
   logic ex_m;
   logic mem_m;
   logic wb_m;

   // raw matches, then priority resolution
   always_comb begin
      live       = use_i && (rs_i != X0);
      ex_m       = live && ex_we_i && (rs_i == ex_wreg_i);
      mem_m      = live && mem_we_i && (rs_i == mem_wreg_i);
      wb_m       = live && wb_we_i && (rs_i == wb_wreg_i);
      ex_fwd_o   = ex_m && !ex_load_i;
      load_use_o = ex_m && ex_load_i;
      mem_fwd_o  = mem_m && !ex_m;
      wb_fwd_o   = wb_m && !ex_m && !mem_m;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects plus keep/nop sequencing.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_wreg,
   input  logic             ex_regwrite,
   input  logic             ex_is_load,
   input  logic [4:0]       mem_wreg,
   input  logic             mem_regwrite,
   input  logic [4:0]       wb_wreg,
   input  logic             wb_regwrite,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic [1:0]       forwarding_ID_EX_pyc,
   output logic [1:0]       forwarding_ID_MEM_pyc,
   output logic [1:0]       forwarding_stall_load_pyc,
   output logic [1:0]       forwarding_ID_MEM_hazard_pyc,
   output logic             pc_keep,
   output logic             ifid_keep,
   output logic             idex_keep,
   output logic             exmem_keep,
   output logic             memwb_keep,
   output logic             ifid_nop,
   output logic             idex_nop,
   output logic             exmem_nop,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

   state_e state_q, state_d;

   logic [1:0] ex_hit;
   logic [1:0] mem_hit;
   logic [1:0] wb_hit;
   logic [1:0] lu_hit;

   logic mem_stall;
   logic flush;
   logic hazard;

   logic br_pend_q, br_pend_d;
   logic [1:0] ld_mask_q, ld_mask_d;
   logic [1:0] mask;

   logic [1:0] ex_pyc_q, ex_pyc_d;
   logic [1:0] mem_pyc_q, mem_pyc_d;
   logic [1:0] ld_pyc_q, ld_pyc_d;
   logic [1:0] wb_pyc_q, wb_pyc_d;

   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic err_q, err_d;

   fwd_match u_rs1 (
      .rs_i       (id_rs1),
      .use_i      (id_use_rs1),
      .ex_wreg_i  (ex_wreg),
      .ex_we_i    (ex_regwrite),
      .ex_load_i  (ex_is_load),
      .mem_wreg_i (mem_wreg),
      .mem_we_i   (mem_regwrite),
      .wb_wreg_i  (wb_wreg),
      .wb_we_i    (wb_regwrite),
      .ex_fwd_o   (ex_hit[RS1_BIT]),
      .mem_fwd_o  (mem_hit[RS1_BIT]),
      .wb_fwd_o   (wb_hit[RS1_BIT]),
      .load_use_o (lu_hit[RS1_BIT])
   );

   fwd_match u_rs2 (
      .rs_i       (id_rs2),
      .use_i      (id_use_rs2),
      .ex_wreg_i  (ex_wreg),
      .ex_we_i    (ex_regwrite),
      .ex_load_i  (ex_is_load),
      .mem_wreg_i (mem_wreg),
      .mem_we_i   (mem_regwrite),
      .wb_wreg_i  (wb_wreg),
      .wb_we_i    (wb_regwrite),
      .ex_fwd_o   (ex_hit[RS2_BIT]),
      .mem_fwd_o  (mem_hit[RS2_BIT]),
      .wb_fwd_o   (wb_hit[RS2_BIT]),
      .load_use_o (lu_hit[RS2_BIT])
   );

   // event priority: memory wait, then flush, then load-use;
   // a branch seen while waiting is parked and flushed once back in RUN
   always_comb begin
      mem_stall = !dmem_ready && (dmem_req || (state_q == MEM_WAIT));
      flush     = (branch_taken || br_pend_q) && !mem_stall
                  && (state_q != MEM_WAIT);
      hazard    = (|lu_hit) && (state_q != LOAD_STALL)
                  && !mem_stall && !flush;
      br_pend_d = flush ? 1'b0 : (br_pend_q || branch_taken);
      ld_mask_d = hazard ? lu_hit : 2'b00;
      state_d   = RUN;
      if (mem_stall)   state_d = MEM_WAIT;
      else if (flush)  state_d = RUN;
      else if (hazard) state_d = LOAD_STALL;
   end

   // keep/nop decode, forced low while reset is asserted
   always_comb begin
      pc_keep    = !rst && (mem_stall || hazard);
      ifid_keep  = !rst && (mem_stall || hazard);
      idex_keep  = !rst && mem_stall;
      exmem_keep = !rst && mem_stall;
      memwb_keep = !rst && mem_stall;
      ifid_nop   = !rst && flush;
      idex_nop   = !rst && (flush || hazard);
      exmem_nop  = !rst && flush;
   end

   // select next-state: bubble clears, wait holds, otherwise load;
   // after a load stall the held source takes the stall-load path
   always_comb begin
      mask      = (state_q == LOAD_STALL) ? ld_mask_q : 2'b00;
      ex_pyc_d  = ex_hit;
      mem_pyc_d = mem_hit & ~mask;
      wb_pyc_d  = wb_hit & ~mask;
      ld_pyc_d  = mask;
      if (flush || hazard) begin
         ex_pyc_d  = 2'b00;
         mem_pyc_d = 2'b00;
         wb_pyc_d  = 2'b00;
         ld_pyc_d  = 2'b00;
      end else if (mem_stall) begin
         ex_pyc_d  = ex_pyc_q;
         mem_pyc_d = mem_pyc_q;
         wb_pyc_d  = wb_pyc_q;
         ld_pyc_d  = ld_pyc_q;
      end
   end

   // saturating wait counter and sticky timeout flag
   always_comb begin
      wcnt_d = '0;
      if (mem_stall)
         wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + 1'b1;
      err_d = err_q || (mem_stall && (wcnt_d == WMAX));
   end

   // FSM and registered selects
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         br_pend_q <= 1'b0;
         ld_mask_q <= 2'b00;
         ex_pyc_q  <= 2'b00;
         mem_pyc_q <= 2'b00;
         ld_pyc_q  <= 2'b00;
         wb_pyc_q  <= 2'b00;
         wcnt_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         br_pend_q <= br_pend_d;
         ld_mask_q <= ld_mask_d;
         ex_pyc_q  <= ex_pyc_d;
         mem_pyc_q <= mem_pyc_d;
         ld_pyc_q  <= ld_pyc_d;
         wb_pyc_q  <= wb_pyc_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
      end
   end

   assign forwarding_ID_EX_pyc         = ex_pyc_q;
   assign forwarding_ID_MEM_pyc        = mem_pyc_q;
   assign forwarding_stall_load_pyc    = ld_pyc_q;
   assign forwarding_ID_MEM_hazard_pyc = wb_pyc_q;
   assign err_timeout                  = err_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   logic [CNT_W-1:0] wait_q;

   // free-running perf counters, wrap on overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
         wait_q  <= '0;
      end else begin
         stall_q <= stall_q
                    + {{(CNT_W-1){1'b0}}, (state_q == LOAD_STALL)};
         flush_q <= flush_q + {{(CNT_W-1){1'b0}}, flush};
         wait_q  <= wait_q + {{(CNT_W-1){1'b0}}, mem_stall};
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
   assign wait_cnt  = wait_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It compares the ID-stage source registers against the destinations in EX, MEM and WB, and registers the four 2-bit forwarding selects consumed by the execute stage. It also sequences the `keep`/`nop` controls of every pipeline register for three cases: load-use stalls, taken-branch flushes and data-memory wait states. It sits beside the decode stage and drives the execute stage's forwarding and keep/nop inputs.

## Interface
Parameters:
- `MAX_WAIT`, 16: dmem wait cycles tolerated before `err_timeout` sets.
- `CNT_W`, 32: perf counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` in 5: sources of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: source is actually read.
- `ex_wreg` in 5, `ex_regwrite` in 1, `ex_is_load` in 1: instruction in EX.
- `mem_wreg` in 5, `mem_regwrite` in 1: instruction in MEM.
- `wb_wreg` in 5, `wb_regwrite` in 1: instruction in WB.
- `branch_taken` in 1: branch/jump resolved taken in MEM.
- `dmem_req` in 1, `dmem_ready` in 1: MEM-stage access handshake.
- `forwarding_ID_EX_pyc`, `forwarding_ID_MEM_pyc`, `forwarding_stall_load_pyc`, `forwarding_ID_MEM_hazard_pyc` out 2 each: bit1 = rs1, bit0 = rs2.
- `pc_keep`, `ifid_keep`, `idex_keep`, `exmem_keep`, `memwb_keep` out 1: hold register.
- `ifid_nop`, `idex_nop`, `exmem_nop` out 1: bubble register.
- `err_timeout` out 1: sticky wait-timeout flag.
- `stall_cnt`, `flush_cnt`, `wait_cnt` out CNT_W: perf counters.

## Operation
- Match condition: `id_rsN == X_wreg && X_regwrite && id_use_rsN && id_rsN != 0`. Register x0 never matches.
- Forward priority per source is EX > MEM > WB. Only the highest-priority match is set:
  - EX match on a non-load sets `forwarding_ID_EX_pyc`.
  - MEM match sets `forwarding_ID_MEM_pyc`.
  - WB match sets `forwarding_ID_MEM_hazard_pyc`.
- Load-use: an EX match with `ex_is_load` is a hazard.
  - Drive `pc_keep`, `ifid_keep` and `idex_nop` for one cycle.
  - On the next cycle, set `forwarding_stall_load_pyc` for the matching source(s) when the instruction enters EX.
- Pyc registers:
  - Load the new selects when ID/EX advances.
  - Clear to 0 on `idex_nop`.
  - Hold on `idex_keep`.
- FSM states are RUN, LOAD_STALL, MEM_WAIT.
  - RUN → MEM_WAIT when `dmem_req && !dmem_ready`.
  - RUN → LOAD_STALL on a load-use hazard.
  - LOAD_STALL → RUN unconditionally after 1 cycle. No back-to-back stall on the same instruction.
  - MEM_WAIT → RUN when `dmem_ready`.
- In MEM_WAIT all `*_keep` outputs are 1 and all `*_nop` outputs are 0. The pyc registers hold.
- Wait counter:
  - Increments each MEM_WAIT cycle and saturates at MAX_WAIT.
  - Reaching MAX_WAIT sets `err_timeout`, which stays set until `rst`.
  - The counter clears on exit from MEM_WAIT.
- Flush: `branch_taken` (not in MEM_WAIT) drives `ifid_nop`, `idex_nop` and `exmem_nop` for one cycle and clears all pyc registers.
- Simultaneous events, highest priority first:
  - MEM_WAIT entry/hold: `branch_taken` is ignored until ready and then honoured.
  - Branch flush: it cancels any load-use hazard in the same cycle, and FSM → RUN.
  - Load-use stall.
- Keep/nop outputs are combinational decodes of state and inputs.

## Timing
- Reset values:
  - FSM = RUN.
  - All pyc registers = 2'b00.
  - All keep/nop = 0.
  - `err_timeout` = 0.
  - Counters = 0.
  - Wait counter = 0.
- Forward-select latency: 1 cycle. Selects computed while the instruction is in ID are valid while it is in EX.
- Load-use costs exactly 1 bubble.
- Flush costs 3 bubbles.
- A memory wait costs N stall cycles, where N is the number of cycles `dmem_ready` stays low.
- `rst` asserted mid-stall or mid-wait returns to RUN on the next edge. Keep/nop go to 0 in the same cycle.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` counts LOAD_STALL cycles.
  - `flush_cnt` counts flush cycles.
  - `wait_cnt` counts MEM_WAIT cycles.
  - All three wrap modulo 2^CNT_W.
- Not defined: the counter ports remain and are tied to 0. No counter flops are built.

## Structure
- `hazard_pkg` holds:
  - The FSM state encoding (RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2).
  - The pyc bit positions (RS1_BIT=1, RS2_BIT=0).
  - The x0 constant.
- One sub-module, `fwd_match`: the combinational source-vs-destination comparator, instantiated for rs1 and rs2.

## Test plan
- `add x5` in EX, ID reads rs1=x5, rs2=x5 → next cycle `forwarding_ID_EX_pyc`=2'b11, no keep/nop.
- `lw x7` in EX, ID reads rs2=x7:
  - Cycle 0: `pc_keep`=`ifid_keep`=`idex_nop`=1.
  - Cycle 1: `forwarding_stall_load_pyc`=2'b01.
  - With `HAZARD_PERF_EN`: `stall_cnt`=1.
- ID reads x0, with EX, MEM and WB all writing x0 → all pyc=0.
- `branch_taken`=1 coincident with a load-use hazard → `ifid_nop`=`idex_nop`=`exmem_nop`=1, no keep, all pyc cleared, FSM=RUN.
- `dmem_req`=1, `dmem_ready` low 3 cycles → all keep=1 for 3 cycles. `branch_taken` pulsed during the wait is deferred and flushes the cycle after ready.
- `dmem_ready` held low 20 cycles with MAX_WAIT=16 → `err_timeout`=1 from the 16th wait cycle. It stays 1 after ready and clears only on `rst`.
